// File: rtl/ram_ctrl_if.sv
// ============================================================================
// Module      : ram_ctrl_if
// Description : Processor-side request/response bus of ram_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/ram_ctrl.sv
// ============================================================================
// Module      : ram_ctrl
// Description : Word request initiator for a byte-write / word-read 2048x8
//               synchronous RAM. Optional macro RAM_CTRL_ALIGN_CHECK_EN
//               rejects odd addresses with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_ctrl (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ram_ctrl_if.slave        bus,
    output logic [10:0]      ram_addr,
    output logic             ram_we_n,
    output logic             ram_ena,
    output logic [7:0]       ram_din,
    input  wire logic [15:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_CAPT  = 3'd2,
        S_WR_LO    = 3'd3,
        S_WR_HI    = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rdata;
    logic [7:0]  r_wdata_hi;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
    logic        r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 16'h0000;
            r_wdata_hi  <= 8'h00;
            ram_addr    <= 11'h000;
            ram_we_n    <= 1'b1;
            ram_ena     <= 1'b0;
            ram_din     <= 8'h00;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_ready) begin
                        r_ready <= 1'b0;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
                        r_err   <= 1'b0;
                        // Misaligned requests skip the RAM entirely
                        if (bus.req_addr[0]) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end else
`endif
                        if (bus.req_we) begin
                            r_state    <= S_WR_LO;
                            ram_ena    <= 1'b1;
                            ram_we_n   <= 1'b0;
                            ram_addr   <= bus.req_addr;
                            ram_din    <= bus.req_wdata[7:0];
                            r_wdata_hi <= bus.req_wdata[15:8];
                        end else begin
                            r_state  <= S_RD_ISSUE;
                            ram_ena  <= 1'b1;
                            ram_we_n <= 1'b1;
                            ram_addr <= bus.req_addr;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    ram_ena <= 1'b0;
                    r_state <= S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    r_rdata     <= ram_dout;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_WR_LO: begin
                    // 11-bit add wraps 0x7FF to 0x000
                    ram_addr <= ram_addr + 11'd1;
                    ram_din  <= r_wdata_hi;
                    r_state  <= S_WR_HI;
                end
                S_WR_HI: begin
                    ram_ena     <= 1'b0;
                    ram_we_n    <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    ram_ena  <= 1'b0;
                    ram_we_n <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
    assign bus.rsp_err   = r_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// ============================================================================
// Module      : tb_ram_ctrl
// Description : Scoreboard bench for ram_ctrl with a behavioural 2048x8 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] ram_addr;
    logic        ram_we_n;
    logic        ram_ena;
    logic [7:0]  ram_din;
    logic [15:0] ram_dout;

    ram_ctrl_if bus ();

    ram_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_we_n (ram_we_n),
        .ram_ena  (ram_ena),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: the read port does not wrap past 0x7FF
    logic [7:0] mem [0:2047];
    initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (ram_ena) begin
            if (!ram_we_n) begin
                mem[ram_addr] <= ram_din;
            end else begin
                logic [11:0] hi_idx;
                hi_idx = {1'b0, ram_addr} + 12'd1;
                ram_dout <= {(hi_idx[11] ? 8'hxx : mem[hi_idx[10:0]]), mem[ram_addr]};
            end
        end
    end

    typedef struct {
        int          cyc;
        bit          rd;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                    if (e.rd) chk("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.rdata});
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                void'(sb.pop_front());
                chk("rsp_missing", {31'd0, bus.rsp_valid}, 32'd1);
            end
            if (bus.req_ready || bus.rsp_valid)
                chk("ena_idle_resp", {31'd0, ram_ena}, 32'd0);
        end
    end

    // Called right after a falling edge; returns at the falling edge after acceptance
    task automatic do_req(input bit we, input logic [10:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input bit exp_err,
                          input bit chain, input bit push);
        int n;
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (chain) chk("accept_spacing", cyc - last_acc, 32'd4);
        last_acc = cyc;
        if (push) begin
            e.cyc   = exp_err ? cyc + 1 : cyc + 3;
            e.rd    = !we;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 11'h000;
        bus.req_wdata = 16'h0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst_ram_ena",   {31'd0, ram_ena},       32'd0);
        chk("rst_ram_we_n",  {31'd0, ram_we_n},      32'd1);
        chk("rst_ram_addr",  {21'd0, ram_addr},      32'd0);
        chk("rst_ram_din",   {24'd0, ram_din},       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0xBEEF to 0x010, ready low for the whole operation
        do_req(1'b1, 11'h010, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            chk("ready_low_busy", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("wr_lo_byte", {24'd0, mem[11'h010]}, 32'hEF);
        chk("wr_hi_byte", {24'd0, mem[11'h011]}, 32'hBE);

        // Back-to-back read-back, then a continuous alternating stream
        do_req(1'b0, 11'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        do_req(1'b1, 11'h100, 16'h1111, 16'h0000, 1'b0, 1'b1, 1'b1);
        do_req(1'b0, 11'h100, 16'h0000, 16'h1111, 1'b0, 1'b1, 1'b1);
        do_req(1'b1, 11'h102, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b1);
        do_req(1'b0, 11'h102, 16'h0000, 16'h2222, 1'b0, 1'b1, 1'b1);
        do_req(1'b0, 11'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        drain();

`ifdef RAM_CTRL_ALIGN_CHECK_EN
        // Misaligned read: error one cycle after acceptance, rdata unchanged
        do_req(1'b0, 11'h011, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        drain();
        do_req(1'b1, 11'h031, 16'h00FF, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        drain();
        chk("misaligned_no_write", {24'd0, mem[11'h031]}, 32'h00);
`else
        // Write across the top of the address space wraps the high byte
        do_req(1'b1, 11'h7FF, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
        drain();
        chk("wrap_lo_byte", {24'd0, mem[11'h7FF]}, 32'h34);
        chk("wrap_hi_byte", {24'd0, mem[11'h000]}, 32'h12);
        do_req(1'b0, 11'h7FE, 16'h0000, 16'h3400, 1'b0, 1'b0, 1'b1);
        drain();
`endif

        // Reset in WR_HI of a write to 0x020: only the low byte lands
        do_req(1'b1, 11'h020, 16'hAA55, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("mid_rst_ram_ena",   {31'd0, ram_ena},       32'd0);
        chk("mid_rst_ram_we_n",  {31'd0, ram_we_n},      32'd1);
        chk("mid_rst_ram_addr",  {21'd0, ram_addr},      32'd0);
        chk("mid_rst_ram_din",   {24'd0, ram_din},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("partial_lo_byte", {24'd0, mem[11'h020]}, 32'h55);
        chk("partial_hi_byte", {24'd0, mem[11'h021]}, 32'h00);
        do_req(1'b0, 11'h020, 16'h0000, 16'h0055, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ram_ctrl.md
# ram_ctrl

Request-driven initiator for the platform's byte-wide, 2048-address synchronous RAM block. It has a write port of 8 bits and a read port of 16 bits that returns the bytes at addr and addr+1, low byte first. The controller accepts 16-bit word read and write requests from the processor-side bus over a valid/ready handshake. It sequences the RAM's `addr`/`we_n`/`ena`/`din` pins and returns read data or a write acknowledge as a one-cycle response pulse. It sits between the core's load/store unit and the RAM instance in the memory subsystem.

## Interface
- No parameters; widths are fixed by the RAM (11-bit address, 8-bit write, 16-bit read).
- `clk` input 1: single clock, rising edge; shared with the RAM.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; high only in IDLE.
- `req_we` input 1: 1 = word write, 0 = word read.
- `req_addr` input 11: byte address of the low byte.
- `req_wdata` input 16: write data; [7:0] goes to `req_addr`, [15:8] goes to `req_addr+1`.
- `rsp_valid` output 1: one-cycle completion pulse, for both reads and writes.
- `rsp_rdata` output 16: read data; holds its value until the next read completes.
- `rsp_err` output 1: qualified by `rsp_valid`; only driven when the alignment check is compiled in.
- `ram_addr` output 11: to RAM `addr`.
- `ram_we_n` output 1: to RAM `we_n`.
- `ram_ena` output 1: to RAM `ena`.
- `ram_din` output 8: to RAM `din`.
- `ram_dout` input 16: from RAM `dout`.

## Operation
- All RAM-side outputs and response outputs are registered. There is no combinational path from `req_*` to `ram_*`.
- A request is accepted on a rising edge where `req_valid & req_ready`. The address, data and direction are captured internally at that edge.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, WR_LO, WR_HI, RESP.
- IDLE: `ram_ena`=0, `ram_we_n`=1, `req_ready`=1.
  - Accepted read → RD_ISSUE.
  - Accepted write → WR_LO.
- RD_ISSUE: `ram_ena`=1, `ram_we_n`=1, `ram_addr`=A. Next state is RD_CAPT.
- RD_CAPT: `ram_ena`=0. At the edge leaving this state, `rsp_rdata`←`ram_dout`. Next state is RESP.
- WR_LO: `ram_ena`=1, `ram_we_n`=0, `ram_addr`=A, `ram_din`=D[7:0]. Next state is WR_HI.
- WR_HI: `ram_ena`=1, `ram_we_n`=0, `ram_addr`=A+1, `ram_din`=D[15:8]. Next state is RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, `ram_ena`=0. Next state is IDLE.
- Address arithmetic is 11-bit modulo: A+1 from 0x7FF wraps to 0x000.
- A `req_valid` asserted while `req_ready`=0 is ignored. The requester holds the request until it is accepted.
- There is no response back-pressure: the consumer must sample `rsp_valid` in the cycle it is high.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ram_ena`=0, `ram_we_n`=1, `ram_addr`=0, `ram_din`=0.
- Reset asserted mid-operation returns the FSM to IDLE immediately and no response is issued.
  - A write interrupted after WR_LO leaves only the low byte written. This is accepted behaviour.

## Timing
- Acceptance edge is E0.
- Read:
  - The RAM samples the read at E1.
  - `ram_dout` is valid after E1 and captured at E2.
  - `rsp_valid` is high in the cycle after E2, which is 3 cycles after E0.
- Write:
  - Low byte is written at E1, high byte at E2.
  - `rsp_valid` is high in the cycle after E2.
- Throughput: one request per 4 cycles. The next acceptance can occur at the edge that ends RESP+1, i.e. `req_ready` rises in the cycle after RESP.
- `rsp_rdata` is stable from the RESP cycle until the next read's capture edge.

## Configuration
- Macro `RAM_CTRL_ALIGN_CHECK_EN`.
- Defined:
  - A request with `req_addr[0]`=1 is accepted but goes IDLE→RESP directly, with no RAM access (`ram_ena` stays 0).
  - The response has `rsp_err`=1, and `rsp_rdata` is unchanged.
  - Aligned requests complete with `rsp_err`=0.
  - Total latency of the error path: `rsp_valid` in the cycle after E0.
- Undefined:
  - All addresses are serviced and `rsp_err` is tied 0.
  - A write at 0x7FF places the high byte at 0x000.
  - A read at 0x7FF returns an undefined high byte, because the RAM does not wrap its read address.

## Test plan
- After reset, write 0xBEEF to 0x010. Expected:
  - RAM writes 0xEF@0x010 at E1 and 0xBE@0x011 at E2.
  - `rsp_valid` pulses once, 3 cycles after E0.
  - `req_ready`=0 during the operation.
- Read 0x010 after the write above → `rsp_rdata`=0xBEEF with `rsp_valid` pulsed 3 cycles after acceptance. Write-then-read back to back is accepted on the first legal `req_ready` cycle.
- Hold `req_valid`=1 continuously with alternating read and write requests. Expected:
  - Exactly one acceptance per 4 cycles.
  - `ram_ena` is never high in IDLE or RESP.
  - No request is lost or duplicated.
- Write 0x1234 to 0x7FF with the macro undefined. Expected: 0x34@0x7FF, 0x12@0x000. Then read 0x7FE → low byte of `rsp_rdata` is 0x00 if the location was prewritten to 0, and high byte is 0x34.
- With `RAM_CTRL_ALIGN_CHECK_EN` defined, read 0x011. Expected:
  - `rsp_valid` and `rsp_err`=1 in the cycle after E0.
  - `ram_ena` never asserts.
  - `rsp_rdata` is unchanged.
- Assert `rst_n`=0 in the WR_HI cycle of a write to 0x020 (data 0xAA55). Expected:
  - All outputs take their reset values asynchronously.
  - No `rsp_valid` is issued.
  - A subsequent read returns low byte 0x55.
